// File: rtl/board_pkg.sv
// Shared types and constants for the minesweeper board controller.
package board_pkg;

    localparam int         N    = 8;
    localparam logic [3:0] MINE = 4'hf;

    typedef enum logic [3:0] {
        HIDDEN   = 4'd0,
        REVEALED = 4'd1,
        FLAGGED  = 4'd2
    } cell_e;

    localparam logic [2:0] ST_PLAY  = 3'd0;
    localparam logic [2:0] ST_SWEEP = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_LOST  = 3'd3;
    localparam logic [2:0] ST_WON   = 3'd4;

    typedef logic [N-1:0][N-1:0][3:0] board_t;

endpackage

// File: rtl/board_ctrl_neighbor_zero.sv
// Flags a cell that touches an already revealed zero cell; drives the flood-fill sweep.
import board_pkg::*;

module neighbor_zero (
    input  board_t     mj,
    input  board_t     mnum,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic       hit
);

    int nx_s;
    int ny_s;

    // Scan the 3x3 window around (x,y), skipping the centre and off-board positions.
    always_comb begin
        hit  = 1'b0;
        nx_s = 0;
        ny_s = 0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                nx_s = int'(x) + dx;
                ny_s = int'(y) + dy;
                if ((dx != 0 || dy != 0) && nx_s >= 0 && nx_s < N && ny_s >= 0 && ny_s < N) begin
                    if (mj[nx_s[2:0]][ny_s[2:0]] == REVEALED && mnum[nx_s[2:0]][ny_s[2:0]] == 4'd0) begin
                        hit = 1'b1;
                    end else begin
                        hit = hit;
                    end
                end else begin
                    hit = hit;
                end
            end
        end
    end

endmodule

// File: rtl/board_ctrl.sv
// Minesweeper game controller: cursor, cell-state matrix, flood-fill reveal, win/loss.
import board_pkg::*;

module board_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_reveal,
    input  logic       btn_flag,
    input  board_t     mNum,
    output logic [2:0] pos_x,
    output logic [2:0] pos_y,
    output board_t     mJ,
    output logic       busy,
    output logic       game_over,
    output logic       win,
    output logic [6:0] flags
);

    logic [2:0] state_r;
    logic [2:0] state_nx_s;
    logic [5:0] k_r;
    logic       changed_r;
    logic [3:0] cur_s;
    logic [3:0] cur_num_s;
    logic [2:0] sx_s;
    logic [2:0] sy_s;
    logic       nz_hit_s;
    logic       sweep_set_s;
    logic       all_clear_s;

    assign cur_s     = mJ[pos_x][pos_y];
    assign cur_num_s = mNum[pos_x][pos_y];
    assign sx_s      = k_r[2:0];
    assign sy_s      = k_r[5:3];

    neighbor_zero u_nz (
        .mj   (mJ),
        .mnum (mNum),
        .x    (sx_s),
        .y    (sy_s),
        .hit  (nz_hit_s)
    );

    assign sweep_set_s = (mJ[sx_s][sy_s] == HIDDEN) && (mNum[sx_s][sy_s] != MINE) && nz_hit_s;

    // Board is won once every non-mine cell is revealed.
    always_comb begin
        all_clear_s = 1'b1;
        for (int x = 0; x < N; x++) begin
            for (int y = 0; y < N; y++) begin
                if (mJ[x][y] != REVEALED && mNum[x][y] != MINE) begin
                    all_clear_s = 1'b0;
                end else begin
                    all_clear_s = all_clear_s;
                end
            end
        end
    end

    // Game state transitions; new_game overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (new_game) begin
            state_nx_s = ST_PLAY;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (btn_reveal && cur_s == HIDDEN) begin
                        if (cur_num_s == MINE) begin
                            state_nx_s = ST_LOST;
                        end else if (cur_num_s == 4'd0) begin
                            state_nx_s = ST_SWEEP;
                        end else begin
                            state_nx_s = ST_CHECK;
                        end
                    end else begin
                        state_nx_s = ST_PLAY;
                    end
                end
                ST_SWEEP: begin
                    if (k_r == 6'd63 && !(changed_r || sweep_set_s)) begin
                        state_nx_s = ST_CHECK;
                    end else begin
                        state_nx_s = ST_SWEEP;
                    end
                end
                ST_CHECK: begin
                    if (all_clear_s) begin
                        state_nx_s = ST_WON;
                    end else begin
                        state_nx_s = ST_PLAY;
                    end
                end
                ST_LOST: state_nx_s = ST_LOST;
                ST_WON:  state_nx_s = ST_WON;
                default: state_nx_s = ST_PLAY;
            endcase
        end
    end

    // All controller state, including the status outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_PLAY;
            k_r       <= 6'd0;
            changed_r <= 1'b0;
            mJ        <= '0;
            pos_x     <= 3'd0;
            pos_y     <= 3'd0;
            flags     <= 7'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            busy      <= (state_nx_s == ST_SWEEP) || (state_nx_s == ST_CHECK);
            game_over <= (state_nx_s == ST_LOST);
            win       <= (state_nx_s == ST_WON);
            if (new_game) begin
                k_r       <= 6'd0;
                changed_r <= 1'b0;
                mJ        <= '0;
                pos_x     <= 3'd0;
                pos_y     <= 3'd0;
                flags     <= 7'd0;
            end else begin
                case (state_r)
                    ST_PLAY: begin
                        k_r       <= 6'd0;
                        changed_r <= 1'b0;
                        if (btn_reveal) begin
                            if (cur_s == HIDDEN) begin
                                mJ[pos_x][pos_y] <= REVEALED;
                            end
                        end else if (btn_flag) begin
                            if (cur_s == HIDDEN && flags != 7'd64) begin
                                mJ[pos_x][pos_y] <= FLAGGED;
                                flags            <= flags + 7'd1;
                            end else if (cur_s == FLAGGED && flags != 7'd0) begin
                                mJ[pos_x][pos_y] <= HIDDEN;
                                flags            <= flags - 7'd1;
                            end
                        end else if (btn_up) begin
                            if (pos_y != 3'd0) pos_y <= pos_y - 3'd1;
                        end else if (btn_down) begin
                            if (pos_y != 3'd7) pos_y <= pos_y + 3'd1;
                        end else if (btn_left) begin
                            if (pos_x != 3'd0) pos_x <= pos_x - 3'd1;
                        end else if (btn_right) begin
                            if (pos_x != 3'd7) pos_x <= pos_x + 3'd1;
                        end
                    end
                    ST_SWEEP: begin
                        if (sweep_set_s) mJ[sx_s][sy_s] <= REVEALED;
                        if (k_r == 6'd63) begin
                            k_r       <= 6'd0;
                            changed_r <= 1'b0;
                        end else begin
                            k_r       <= k_r + 6'd1;
                            changed_r <= changed_r | sweep_set_s;
                        end
                    end
                    ST_LOST: begin
                        // Expose hidden mines; flagged mines keep their flag.
                        for (int x = 0; x < N; x++) begin
                            for (int y = 0; y < N; y++) begin
                                if (mNum[x][y] == MINE && mJ[x][y] == HIDDEN) mJ[x][y] <= REVEALED;
                            end
                        end
                    end
                    default: begin
                        k_r <= k_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: directed scenarios plus randomized games vs. a set-based reference model.
module tb_board_ctrl;
    import board_pkg::*;

    localparam int LIMIT = 64 * 66 + 20;

    logic clk = 1'b0;
    logic rst, new_game, btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;
    board_t mNum, mJ;
    logic [2:0] pos_x, pos_y;
    logic busy, game_over, win;
    logic [6:0] flags;

    always #5 clk = ~clk;

    board_ctrl dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_reveal(btn_reveal), .btn_flag(btn_flag), .mNum(mNum),
        .pos_x(pos_x), .pos_y(pos_y), .mJ(mJ), .busy(busy),
        .game_over(game_over), .win(win), .flags(flags)
    );

    typedef struct {
        int         due;
        logic [2:0] x;
        logic [2:0] y;
        logic [6:0] fl;
        logic       bz;
        logic       go;
        logic       wn;
        board_t     mj;
    } exp_t;

    exp_t idle_q[$];
    exp_t timed_q[$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idle_wait = 0;

    // reference model: game state 0 play, 1 lost, 2 won
    int m_mj[8][8];
    int m_num[8][8];
    int m_x, m_y, m_flags, m_st;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic board_t pack(input int a[8][8]);
        board_t b;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                b[x][y] = 4'(a[x][y]);
        return b;
    endfunction

    function automatic void m_clear();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                m_mj[x][y] = 0;
        m_x = 0; m_y = 0; m_flags = 0; m_st = 0;
    endfunction

    // Worklist flood: every revealed zero exposes its hidden non-mine neighbours.
    function automatic void m_flood();
        int qx[$];
        int qy[$];
        int cx, cy, nx, ny;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                if (m_mj[x][y] == 1 && m_num[x][y] == 0) begin qx.push_back(x); qy.push_back(y); end
        while (qx.size() > 0) begin
            cx = qx.pop_front(); cy = qy.pop_front();
            for (int dx = -1; dx <= 1; dx++)
                for (int dy = -1; dy <= 1; dy++) begin
                    nx = cx + dx; ny = cy + dy;
                    if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8 && m_mj[nx][ny] == 0 && m_num[nx][ny] != 15) begin
                        m_mj[nx][ny] = 1;
                        if (m_num[nx][ny] == 0) begin qx.push_back(nx); qy.push_back(ny); end
                    end
                end
        end
    endfunction

    function automatic bit m_all_clear();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                if (m_num[x][y] != 15 && m_mj[x][y] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // b = {new_game, reveal, flag, up, down, left, right}
    function automatic void m_step(input logic [6:0] b);
        if (b[6]) begin m_clear(); return; end
        if (m_st == 1) begin
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    if (m_num[x][y] == 15 && m_mj[x][y] == 0) m_mj[x][y] = 1;
            return;
        end
        if (m_st == 2) return;
        if (b[5]) begin
            if (m_mj[m_x][m_y] == 0) begin
                m_mj[m_x][m_y] = 1;
                if (m_num[m_x][m_y] == 15) m_st = 1;
                else begin
                    if (m_num[m_x][m_y] == 0) m_flood();
                    if (m_all_clear()) m_st = 2;
                end
            end
        end else if (b[4]) begin
            if (m_mj[m_x][m_y] == 0) begin m_mj[m_x][m_y] = 2; m_flags++; end
            else if (m_mj[m_x][m_y] == 2) begin m_mj[m_x][m_y] = 0; m_flags--; end
        end else if (b[3]) m_y = (m_y > 0) ? m_y - 1 : 0;
        else if (b[2]) m_y = (m_y < 7) ? m_y + 1 : 7;
        else if (b[1]) m_x = (m_x > 0) ? m_x - 1 : 0;
        else if (b[0]) m_x = (m_x < 7) ? m_x + 1 : 7;
    endfunction

    task automatic fill_counts();
        int c;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                if (m_num[x][y] != 15) begin
                    c = 0;
                    for (int dx = -1; dx <= 1; dx++)
                        for (int dy = -1; dy <= 1; dy++)
                            if (x+dx >= 0 && x+dx < 8 && y+dy >= 0 && y+dy < 8 && m_num[x+dx][y+dy] == 15) c++;
                    m_num[x][y] = c;
                end
    endtask

    task automatic set_all(input int v);
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                m_num[x][y] = v;
    endtask

    task automatic push_idle();
        exp_t e;
        e.due = -1; e.x = 3'(m_x); e.y = 3'(m_y); e.fl = 7'(m_flags); e.bz = 1'b0;
        e.go = (m_st == 1); e.wn = (m_st == 2); e.mj = pack(m_mj);
        idle_q.push_back(e);
    endtask

    task automatic push_busy(input int due, input logic v);
        exp_t e;
        e = '{default: '0};
        e.due = due; e.bz = v;
        timed_q.push_back(e);
    endtask

    task automatic clear_btns();
        {new_game, btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 7'd0;
    endtask

    task automatic issue(input logic [6:0] b, input bit do_push);
        if (b[6]) mNum = pack(m_num);
        {new_game, btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk); #1;
        clear_btns();
        m_step(b);
        if (do_push) push_idle();
    endtask

    // Hammer random buttons while busy; they must all be dropped.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < LIMIT) begin
            {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 6'($urandom_range(0, 63));
            @(posedge clk); #1;
            n++;
        end
        clear_btns();
        chk("busy_timeout", 256'(busy), 256'(0));
    endtask

    task automatic cmd(input logic [6:0] b);
        issue(b, 1'b1);
        wait_idle();
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int n = 0;
        while ((m_x != tx || m_y != ty) && n < 20) begin
            if (m_x < tx) cmd(7'b0000001);
            else if (m_x > tx) cmd(7'b0000010);
            else if (m_y < ty) cmd(7'b0000100);
            else cmd(7'b0001000);
            n++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations and compares them against the DUT outputs.
    initial forever begin
        @(negedge clk);
        while (timed_q.size() > 0 && timed_q[0].due <= cyc) begin
            mon_e = timed_q.pop_front();
            if (mon_e.due == cyc) chk("busy_timing", 256'(busy), 256'(mon_e.bz));
            else chk("busy_timing_missed", 256'(mon_e.due), 256'(cyc));
        end
        if (idle_q.size() > 0) begin
            if (!busy) begin
                mon_e = idle_q.pop_front();
                idle_wait = 0;
                chk("pos_x", 256'(pos_x), 256'(mon_e.x));
                chk("pos_y", 256'(pos_y), 256'(mon_e.y));
                chk("flags", 256'(flags), 256'(mon_e.fl));
                chk("busy", 256'(busy), 256'(mon_e.bz));
                chk("game_over", 256'(game_over), 256'(mon_e.go));
                chk("win", 256'(win), 256'(mon_e.wn));
                chk("mJ", 256'(mJ), 256'(mon_e.mj));
            end else begin
                idle_wait++;
                if (idle_wait > LIMIT) begin
                    mon_e = idle_q.pop_front();
                    idle_wait = 0;
                    chk("monitor_timeout", 256'(busy), 256'(0));
                end
            end
        end
    end

    initial begin
        int c0;
        int n;
        rst = 1'b1;
        clear_btns();
        set_all(0);
        mNum = pack(m_num);
        m_clear();
        push_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // cursor saturation
        repeat (9) cmd(7'b0000001);
        repeat (3) cmd(7'b0001000);
        cmd(7'b0000010);

        // flag toggle and reveal on a flagged cell
        goto_xy(2, 3);
        cmd(7'b0010000);
        cmd(7'b0010000);
        cmd(7'b0010000);
        cmd(7'b0100000);
        cmd(7'b0010000);
        cmd(7'b0011111);

        // zero reveal with two sweep passes, mine at (7,7)
        set_all(3);
        m_num[0][0] = 0; m_num[1][0] = 1; m_num[0][1] = 1; m_num[1][1] = 1; m_num[7][7] = 15;
        cmd(7'b1000000);
        issue(7'b0100000, 1'b1);
        c0 = cyc;
        push_busy(c0, 1'b1);
        push_busy(c0 + 128, 1'b1);
        push_busy(c0 + 129, 1'b0);
        wait_idle();

        // new_game mid-sweep with a coincident move
        cmd(7'b1000000);
        issue(7'b0100000, 1'b0);
        c0 = cyc;
        push_busy(c0 + 2, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        cmd(7'b1000001);

        // loss: mines at (4,4), (1,1) and flagged (2,2)
        set_all(0);
        m_num[4][4] = 15; m_num[1][1] = 15; m_num[2][2] = 15;
        fill_counts();
        cmd(7'b1000000);
        goto_xy(2, 2);
        cmd(7'b0010000);
        goto_xy(4, 4);
        cmd(7'b0100000);
        cmd(7'b0001000);
        cmd(7'b0000010);

        // win: single mine at (0,0), everything else zero
        set_all(0);
        m_num[0][0] = 15;
        cmd(7'b1000000);
        goto_xy(7, 7);
        cmd(7'b0100000);
        cmd(7'b0110001);

        // randomized games on legal boards
        for (int g = 0; g < 20; g++) begin
            set_all(0);
            n = 0;
            while (n < int'($urandom_range(1, 10))) begin
                c0 = int'($urandom_range(0, 63));
                if (m_num[c0 % 8][c0 / 8] != 15) begin m_num[c0 % 8][c0 / 8] = 15; n++; end
            end
            fill_counts();
            cmd(7'b1000000);
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 3) == 0) cmd(7'($urandom_range(0, 63)));
                else cmd(7'(1 << $urandom_range(0, 5)));
            end
        end

        n = 0;
        while ((idle_q.size() > 0 || timed_q.size() > 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 256'(idle_q.size() + timed_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
- Game controller for the 8x8 minesweeper board that the rect generator draws.
- Owns the cursor (pos_x/pos_y) and the per-cell state matrix mJ.
- Executes user commands: move, flag, reveal, new game.
- Sequences flood-fill reveal of zero cells and detects win/loss.
- Sits between the button debouncer and the renderer. Reads mNum from the board generator.

Parameters:
- N, 8, board dimension. Fixed at 8 for the 3-bit cursor; kept as a named constant only.
- MINE, 4'hf, mNum code for a mine.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- new_game  in  1  single-cycle pulse: clear board, restart
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle move pulses
- btn_reveal  in  1  single-cycle pulse: reveal cell under cursor
- btn_flag  in  1  single-cycle pulse: toggle flag under cursor
- mNum  in  [7:0][7:0][3:0]  cell contents; 0-8 = neighbour count, 4'hf = mine; stable while not in new_game
- pos_x, pos_y  out  3 each  cursor column/row
- mJ  out  [7:0][7:0][3:0]  cell state, indexed [x][y]; 0 hidden, 1 revealed, 2 flagged
- busy  out  1  high in SWEEP/CHECK; buttons ignored
- game_over  out  1  high in LOST
- win  out  1  high in WON
- flags  out  7  number of cells currently flagged (0-64)

Behaviour:
- Reset (async, rst=1): mJ all 0, pos=(0,0), state PLAY, busy=0, game_over=0, win=0, flags=0.
- States: PLAY, SWEEP, CHECK, LOST, WON.
- new_game has top priority in every state. Next edge: same values as reset.
- Priority in PLAY when several pulses coincide: new_game > reveal > flag > up > down > left > right. Only one command executes per cycle.
- Moves:
  - up = y-1, down = y+1, left = x-1, right = x+1.
  - Saturate at 0 and 7; no wrap.
  - Take effect on the next edge.
- Flag: mJ 0->2 (flags+1) or 2->0 (flags-1). Revealed cells are unaffected. Next edge.
- Reveal on a flagged or revealed cell: no-op.
- Reveal on a hidden cell, cell set to 1 at the next edge, then:
  - mNum = MINE -> LOST.
  - mNum = 0 -> SWEEP with scan index 0 and changed=0.
  - mNum = 1-8 -> CHECK.
- SWEEP, one cell per cycle, index k = 0..63 (x = k[2:0], y = k[5:3]):
  - If mJ[x][y]==0, mNum!=MINE, and any in-bounds 8-neighbour has mJ==1 and mNum==0: set mJ=1 and changed=1.
  - Flagged cells are never revealed.
  - At k=63: if changed, restart the pass (k=0, changed=0); otherwise go to CHECK.
  - Updates within a pass are visible to later cells of the same pass.
- CHECK (1 cycle): if no cell has mJ!=1 and mNum!=MINE -> WON; else -> PLAY.
- LOST:
  - On entry cycle, every cell with mNum==MINE and mJ==0 is set to 1. Flagged mines stay 2.
  - game_over=1. All buttons except new_game are ignored.
- WON: win=1; frozen until new_game.
- busy=1 in SWEEP and CHECK. Button pulses arriving while busy are dropped, not queued.
- Latency:
  - Number reveal: cell visible 1 cycle after the pulse; PLAY again 2 cycles after.
  - Zero reveal: 64 cycles per pass; passes bounded by 64.
- Reset or new_game mid-SWEEP aborts immediately; no partial state survives.
- flags never underflows or overflows (range 0-64).

Decomposition:
- Package board_pkg:
  - cell-state enum: HIDDEN=0, REVEALED=1, FLAGGED=2
  - MINE constant, N constant
  - game-state enum
  - typedef for the [7:0][7:0][3:0] board matrix
- Sub-module neighbor_zero: combinational; inputs mJ, mNum, x, y; output 1 if any in-bounds neighbour is revealed with count 0. Used by SWEEP.
- All state updates live in one always_ff in board_ctrl.

Test Plan:
- Reset, then 9 right pulses and 3 up pulses -> pos=(7,0). Then left -> pos=(6,0).
- btn_flag twice at (2,3) -> mJ[2][3] goes 2 then 0, flags 1 then 0. btn_reveal while flagged -> mJ unchanged, state PLAY.
- Board with a mine at (7,7), all other cells nonzero except (0,0)=0 and its three neighbours = 1:
  - Reveal (0,0) -> busy high, (0,0),(1,0),(0,1),(1,1) = 1 after one pass, other cells 0.
  - busy drops after 2 passes + CHECK (129 cycles).
- Reveal a mine at (4,4) with another unflagged mine at (1,1) and a flagged mine at (2,2):
  - Next edge: mJ[4][4]=1; entry cycle: mJ[1][1]=1, mJ[2][2] stays 2; game_over=1.
  - Moves are ignored.
- Single mine at (0,0), all others zero:
  - Reveal (7,7) -> flood reveals all 63 non-mine cells -> win=1, mJ[0][0]=0.
- new_game asserted mid-SWEEP together with btn_right -> next edge: mJ all 0, pos=(0,0), busy=0.
